// File: rtl/btn_multi_in_if.sv
// Button conditioner bus: raw pins in, debounced level and event pulses out.
interface btn_multi_in_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] i_btn;
  logic [N_CH-1:0] o_level;
  logic [N_CH-1:0] o_press;
  logic [N_CH-1:0] o_release;
  logic [N_CH-1:0] o_long;
  logic [N_CH-1:0] o_rep;

  modport master (output i_btn, input o_level, o_press, o_release, o_long, o_rep);
  modport slave  (input i_btn, output o_level, o_press, o_release, o_long, o_rep);
endinterface

// File: rtl/btn_multi_in.sv
// Multi-channel push-button conditioner: shared sample tick, per-channel
// sync/debounce and press/release/long/repeat pulse generation.
module btn_ch #(
  parameter int STABLE_N     = 2,
  parameter int LONG_TICKS   = 50,
  parameter int REPEAT_TICKS = 10,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn,
  output logic level,
  output logic press,
  output logic rel,
  output logic lng,
  output logic rep
);
  localparam int HMAX = LONG_TICKS + REPEAT_TICKS;
  localparam int DW   = $clog2(STABLE_N + 1);
  localparam int HW   = $clog2(HMAX + 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(STABLE_N - 1);
  localparam logic [HW-1:0] H_LONG     = HW'(LONG_TICKS);
  localparam logic [HW-1:0] H_MAX      = HW'(HMAX);
  localparam logic [HW-1:0] H_PRE_LONG = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] H_PRE_REP  = HW'(HMAX - 1);

  logic [1:0]    sync;
  logic          s;
  logic [DW-1:0] db;
  logic [HW-1:0] hold;
  logic          armed;
  logic          toggle;

  assign s      = sync[1];
  assign toggle = tick && (s != level) && (db == DB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b00;
    else        sync <= {sync[0], btn ^ ACTIVE_LOW};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      db    <= '0;
      hold  <= '0;
      armed <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
      lng   <= 1'b0;
      rep   <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      lng   <= 1'b0;
      rep   <= 1'b0;
      if (tick) begin
        if (s != level) begin
          if (db == DB_LAST) begin
            level <= s;
            db    <= '0;
            hold  <= '0;
            armed <= 1'b0;
            press <= s;
            rel   <= ~s;
          end else begin
            db <= db + 1'b1;
          end
        end else begin
          db <= '0;
        end
        // Hold timing runs only while pressed and never on the toggle tick,
        // so a release coinciding with long/repeat suppresses them.
        if (level && !toggle) begin
          if (armed && (REPEAT_TICKS > 0) && (hold == H_PRE_REP)) begin
            rep  <= 1'b1;
            hold <= H_LONG;
          end else if (hold != H_MAX) begin
            hold <= hold + 1'b1;
          end
          if (hold == H_PRE_LONG) begin
            lng   <= 1'b1;
            armed <= 1'b1;
          end
        end
      end
    end
  end
endmodule

module btn_multi_in #(
  parameter int N_CH         = 4,
  parameter int BIT_SIZE     = 20,
  parameter int STABLE_N     = 2,
  parameter int LONG_TICKS   = 50,
  parameter int REPEAT_TICKS = 10,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic           clk,
  input  logic           i_rst_n,
  btn_multi_in_if.slave  bus
);
  logic [BIT_SIZE-1:0] tick_cnt;
  logic                tick;
  logic [N_CH-1:0]     level, press, rel, lng, rep;

  // Free-running divider; wraps naturally after all-ones.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) tick_cnt <= '0;
    else          tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick = &tick_cnt;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_ch #(
      .STABLE_N     (STABLE_N),
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk   (clk),
      .rst_n (i_rst_n),
      .tick  (tick),
      .btn   (bus.i_btn[i]),
      .level (level[i]),
      .press (press[i]),
      .rel   (rel[i]),
      .lng   (lng[i]),
      .rep   (rep[i])
    );
  end

  assign bus.o_level   = level;
  assign bus.o_press   = press;
  assign bus.o_release = rel;
  assign bus.o_long    = lng;
  assign bus.o_rep     = rep;
endmodule

// File: tb/tb_btn_multi_in.sv
// Directed bench: three conditioner instances (repeat on, repeat off, active-low)
// with event timestamps compared against hand-derived cycle offsets.
module tb_btn_multi_in;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn;
  logic [3:0] btn_c;

  int checks, errors, cyc;
  int cnt_p[3][4], cnt_r[3][4], cnt_l[3][4], cnt_rp[3][4];
  int first_p[3][4], last_r[3][4], first_l[3][4], first_rp[3][4], last_rp[3][4];
  logic [3:0] pvec_a;

  btn_multi_in_if #(.N_CH(4)) ifa ();
  btn_multi_in_if #(.N_CH(4)) ifb ();
  btn_multi_in_if #(.N_CH(4)) ifc ();

  assign ifa.i_btn = btn;
  assign ifb.i_btn = btn;
  assign ifc.i_btn = btn_c;

  btn_multi_in #(.N_CH(4), .BIT_SIZE(2), .STABLE_N(3), .LONG_TICKS(5), .REPEAT_TICKS(3),
                 .ACTIVE_LOW(1'b0)) dut_a (.clk(clk), .i_rst_n(rst_n), .bus(ifa));
  btn_multi_in #(.N_CH(4), .BIT_SIZE(2), .STABLE_N(3), .LONG_TICKS(5), .REPEAT_TICKS(0),
                 .ACTIVE_LOW(1'b0)) dut_b (.clk(clk), .i_rst_n(rst_n), .bus(ifb));
  btn_multi_in #(.N_CH(4), .BIT_SIZE(2), .STABLE_N(3), .LONG_TICKS(5), .REPEAT_TICKS(3),
                 .ACTIVE_LOW(1'b1)) dut_c (.clk(clk), .i_rst_n(rst_n), .bus(ifc));

  always #5 clk = ~clk;

  task automatic clr_ev();
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < 4; c++) begin
        cnt_p[d][c] = 0;  cnt_r[d][c] = 0;  cnt_l[d][c] = 0;  cnt_rp[d][c] = 0;
        first_p[d][c] = -1; last_r[d][c] = -1; first_l[d][c] = -1;
        first_rp[d][c] = -1; last_rp[d][c] = -1;
      end
    pvec_a = 4'h0;
  endtask

  // Advance n clocks, logging event pulses sampled 1 time unit after each edge.
  task automatic step(input int n);
    logic [2:0][3:0] pr, rl, lg, rp;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      cyc++;
      #1;
      pr = {ifc.o_press,   ifb.o_press,   ifa.o_press};
      rl = {ifc.o_release, ifb.o_release, ifa.o_release};
      lg = {ifc.o_long,    ifb.o_long,    ifa.o_long};
      rp = {ifc.o_rep,     ifb.o_rep,     ifa.o_rep};
      if (ifa.o_press != 4'h0) pvec_a = ifa.o_press;
      for (int d = 0; d < 3; d++)
        for (int c = 0; c < 4; c++) begin
          if (pr[d][c]) begin if (cnt_p[d][c] == 0) first_p[d][c] = cyc; cnt_p[d][c]++; end
          if (rl[d][c]) begin cnt_r[d][c]++; last_r[d][c] = cyc; end
          if (lg[d][c]) begin if (cnt_l[d][c] == 0) first_l[d][c] = cyc; cnt_l[d][c]++; end
          if (rp[d][c]) begin
            if (cnt_rp[d][c] == 0) first_rp[d][c] = cyc;
            cnt_rp[d][c]++;
            last_rp[d][c] = cyc;
          end
        end
    end
  endtask

  task automatic test_reset();
    int n;
    btn = 4'hF; btn_c = 4'hF; rst_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      checks++;
      if ({ifa.o_level, ifa.o_press, ifa.o_release, ifa.o_long, ifa.o_rep} !== 20'h0) begin
        errors++;
        $display("FAIL reset_outs_a cyc=%0d got %h want 0", cyc,
                 {ifa.o_level, ifa.o_press, ifa.o_release, ifa.o_long, ifa.o_rep});
      end
    end
    checks++;
    if ({ifb.o_level, ifc.o_level} !== 8'h0) begin
      errors++; $display("FAIL reset_level_bc got %h want 0", {ifb.o_level, ifc.o_level});
    end
    clr_ev();
    rst_n = 1'b1; n = cyc;
    step(16);
    checks++;
    if (pvec_a !== 4'hF) begin errors++; $display("FAIL reset_press_vec got %h want f", pvec_a); end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (cnt_p[0][c] != 1 || first_p[0][c] != n + 12) begin
        errors++;
        $display("FAIL reset_press_a ch%0d got cnt=%0d at %0d want 1 at %0d", c, cnt_p[0][c], first_p[0][c] - n, 12);
      end
    end
    checks++;
    if (first_p[1][3] != n + 12) begin
      errors++; $display("FAIL reset_press_b got %0d want 12", first_p[1][3] - n);
    end
    checks++;
    if (ifc.o_level !== 4'h0 || cnt_p[2][0] + cnt_p[2][1] + cnt_p[2][2] + cnt_p[2][3] != 0) begin
      errors++; $display("FAIL reset_idle_c got level %h want 0", ifc.o_level);
    end
    btn = 4'h0;
    step(20);
    checks++;
    if (cnt_r[0][0] != 1 || cnt_l[0][0] != 0) begin
      errors++; $display("FAIL reset_release got rel=%0d long=%0d want 1/0", cnt_r[0][0], cnt_l[0][0]);
    end
  endtask

  task automatic test_bounce();
    int n;
    clr_ev();
    for (int seg = 0; seg < 10; seg++) begin
      btn[0] = (seg % 2 == 0);
      step(4);
    end
    checks++;
    if (cnt_p[0][0] != 0 || cnt_r[0][0] != 0 || ifa.o_level[0] !== 1'b0) begin
      errors++; $display("FAIL bounce_quiet got press=%0d rel=%0d want 0/0", cnt_p[0][0], cnt_r[0][0]);
    end
    n = cyc; btn[0] = 1'b1;
    step(16);
    checks++;
    if (cnt_p[0][0] != 1) begin errors++; $display("FAIL bounce_press_cnt got %0d want 1", cnt_p[0][0]); end
    checks++;
    if (first_p[0][0] - n < 11 || first_p[0][0] - n > 14) begin
      errors++; $display("FAIL bounce_latency got %0d want 11..14", first_p[0][0] - n);
    end
    step(40);
    btn[0] = 1'b0;
    step(28);
  endtask

  task automatic test_long_repeat();
    int p;
    clr_ev();
    btn[1] = 1'b1;
    step(16);
    checks++;
    if (cnt_p[0][1] != 1) begin errors++; $display("FAIL lr_press got %0d want 1", cnt_p[0][1]); end
    p = (cnt_p[0][1] > 0) ? first_p[0][1] : cyc;
    while (cyc < p + 58) step(1);
    btn[1] = 1'b0;
    step(40);
    checks++;
    if (cnt_l[0][1] != 1 || first_l[0][1] != p + 20) begin
      errors++; $display("FAIL lr_long got cnt=%0d at %0d want 1 at 20", cnt_l[0][1], first_l[0][1] - p);
    end
    checks++;
    if (first_rp[0][1] != p + 32) begin
      errors++; $display("FAIL lr_first_rep got %0d want 32", first_rp[0][1] - p);
    end
    checks++;
    if (cnt_rp[0][1] != 4 || last_rp[0][1] != p + 68) begin
      errors++; $display("FAIL lr_rep got cnt=%0d last=%0d want 4 last=68", cnt_rp[0][1], last_rp[0][1] - p);
    end
    checks++;
    if (cnt_r[0][1] != 1 || last_r[0][1] != p + 72) begin
      errors++; $display("FAIL lr_release got cnt=%0d at %0d want 1 at 72", cnt_r[0][1], last_r[0][1] - p);
    end
    checks++;
    if (cnt_l[1][1] != 1 || cnt_rp[1][1] != 0) begin
      errors++; $display("FAIL lr_norep_b got long=%0d rep=%0d want 1/0", cnt_l[1][1], cnt_rp[1][1]);
    end
  endtask

  task automatic test_release_wins();
    int p;
    clr_ev();
    btn[2] = 1'b1;
    step(16);
    p = (cnt_p[0][2] > 0) ? first_p[0][2] : cyc;
    while (cyc < p + 8) step(1);
    btn[2] = 1'b0;
    step(24);
    checks++;
    if (cnt_r[0][2] != 1 || last_r[0][2] != p + 20) begin
      errors++; $display("FAIL rw_release got cnt=%0d at %0d want 1 at 20", cnt_r[0][2], last_r[0][2] - p);
    end
    checks++;
    if (cnt_l[0][2] != 0 || cnt_l[1][2] != 0) begin
      errors++; $display("FAIL rw_long got a=%0d b=%0d want 0/0", cnt_l[0][2], cnt_l[1][2]);
    end
  endtask

  task automatic test_repeat_off();
    int p;
    clr_ev();
    btn[3] = 1'b1;
    step(16);
    p = (cnt_p[1][3] > 0) ? first_p[1][3] : cyc;
    while (cyc < p + 120) step(1);
    checks++;
    if (cnt_l[1][3] != 1 || first_l[1][3] != p + 20) begin
      errors++; $display("FAIL ro_long got cnt=%0d at %0d want 1 at 20", cnt_l[1][3], first_l[1][3] - p);
    end
    checks++;
    if (cnt_rp[1][3] != 0) begin errors++; $display("FAIL ro_rep got %0d want 0", cnt_rp[1][3]); end
    checks++;
    if (cnt_rp[0][3] != 8) begin errors++; $display("FAIL ro_rep_a got %0d want 8", cnt_rp[0][3]); end
    btn[3] = 1'b0;
    step(24);
  endtask

  task automatic test_active_low();
    int n;
    clr_ev();
    n = cyc; btn_c[2] = 1'b0;
    step(16);
    checks++;
    if (ifc.o_level !== 4'b0100) begin errors++; $display("FAIL al_level got %b want 0100", ifc.o_level); end
    checks++;
    if (cnt_p[2][2] != 1 || first_p[2][2] - n < 11 || first_p[2][2] - n > 14) begin
      errors++; $display("FAIL al_press got cnt=%0d lat=%0d want 1 lat 11..14", cnt_p[2][2], first_p[2][2] - n);
    end
    checks++;
    if (cnt_p[2][0] + cnt_p[2][1] + cnt_p[2][3] + cnt_r[2][0] + cnt_r[2][1] + cnt_r[2][3] != 0) begin
      errors++; $display("FAIL al_quiet got %0d other events want 0",
                         cnt_p[2][0] + cnt_p[2][1] + cnt_p[2][3] + cnt_r[2][0] + cnt_r[2][1] + cnt_r[2][3]);
    end
    btn_c[2] = 1'b1;
    step(16);
    checks++;
    if (cnt_r[2][2] != 1 || ifc.o_level !== 4'h0) begin
      errors++; $display("FAIL al_release got cnt=%0d level=%b want 1 0000", cnt_r[2][2], ifc.o_level);
    end
    step(8);
  endtask

  task automatic test_simultaneous();
    int p;
    clr_ev();
    btn[0] = 1'b1; btn[3] = 1'b1;
    step(16);
    p = (cnt_p[0][0] > 0) ? first_p[0][0] : cyc;
    checks++;
    if (pvec_a !== 4'b1001 || first_p[0][3] != p) begin
      errors++; $display("FAIL sim_press got %b dt=%0d want 1001 dt=0", pvec_a, first_p[0][3] - p);
    end
    btn[0] = 1'b0;
    while (cyc < p + 30) step(1);
    checks++;
    if (cnt_r[0][0] != 1 || last_r[0][0] != p + 16 || cnt_r[0][3] != 0) begin
      errors++; $display("FAIL sim_release got ch0=%0d at %0d ch3=%0d want 1 at 16, 0",
                         cnt_r[0][0], last_r[0][0] - p, cnt_r[0][3]);
    end
    checks++;
    if (first_l[0][3] != p + 20 || cnt_l[0][0] != 0) begin
      errors++; $display("FAIL sim_long got ch3 at %0d ch0 cnt=%0d want 20, 0", first_l[0][3] - p, cnt_l[0][0]);
    end
    checks++;
    if (ifa.o_level !== 4'b1000) begin errors++; $display("FAIL sim_level got %b want 1000", ifa.o_level); end
    btn[3] = 1'b0;
    step(24);
  endtask

  task automatic test_reset_mid_hold();
    int n;
    btn[1] = 1'b1;
    step(26);
    clr_ev();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      checks++;
      if ({ifa.o_level, ifa.o_press, ifa.o_release, ifa.o_long, ifa.o_rep} !== 20'h0) begin
        errors++;
        $display("FAIL midrst_outs cyc=%0d got %h want 0", cyc,
                 {ifa.o_level, ifa.o_press, ifa.o_release, ifa.o_long, ifa.o_rep});
      end
    end
    rst_n = 1'b1; n = cyc;
    step(16);
    checks++;
    if (cnt_p[0][1] != 1 || first_p[0][1] != n + 12) begin
      errors++; $display("FAIL midrst_press got cnt=%0d at %0d want 1 at 12", cnt_p[0][1], first_p[0][1] - n);
    end
    checks++;
    if (cnt_r[0][1] + cnt_l[0][1] + cnt_rp[0][1] != 0) begin
      errors++; $display("FAIL midrst_pulses got %0d want 0", cnt_r[0][1] + cnt_l[0][1] + cnt_rp[0][1]);
    end
    btn[1] = 1'b0;
    step(24);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b0; btn = 4'h0; btn_c = 4'hF;
    clr_ev();
    test_reset();
    test_bounce();
    test_long_repeat();
    test_release_wins();
    test_repeat_off();
    test_active_low();
    test_simultaneous();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
